// File: rtl/mod_rem_pkg.sv
// Shared types and elaboration helpers for the serial mod-N remainder block.
package mod_rem_pkg;

  // Sequencer states of the serial divider.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Remainder width: the accumulator always stays below the modulus.
  function automatic int rem_width(input int modulus);
    return $clog2(modulus);
  endfunction

  // A divisor below 2 makes the remainder degenerate.
  function automatic bit modulus_ok(input int modulus);
    return modulus >= 2;
  endfunction

  // The operand must be at least as wide as the remainder.
  function automatic bit width_ok(input int width, input int rw);
    return (width >= rw) && (width >= 1);
  endfunction

endpackage

// File: rtl/mod_rem_step.sv
// One restoring-division step: shift one dividend bit into the partial
// remainder and subtract the modulus when it fits.
module mod_rem_step
  import mod_rem_pkg::*;
#(
  parameter int MODULUS = 7,
  parameter int RW      = rem_width(MODULUS)
) (
  input  logic [RW-1:0] acc_i,
  input  logic          bit_i,
  output logic [RW-1:0] acc_next_o,
  output logic          qbit_o
);

  // The trial value needs one extra bit: 2*acc+1 can exceed 2^RW.
  localparam logic [RW:0] MOD_W = (RW + 1)'(MODULUS);

  logic [RW:0] trial;

  // Compare-and-subtract; the result is again below MODULUS.
  always_comb begin
    trial  = {acc_i, bit_i};
    qbit_o = (trial >= MOD_W);
    if (qbit_o) begin
      acc_next_o = RW'(trial - MOD_W);
    end else begin
      acc_next_o = trial[RW-1:0];
    end
  end

endmodule

// File: rtl/mod_rem_serial.sv
// Bit-serial remainder (and optional quotient) of an unsigned operand by a
// constant modulus, MSB first, one bit per clock.
// Optional build macro MODREM_QUOT_EN adds the out_quot port and register.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid must not depend on ready, and the producer holds data
// stable while valid is high. in_ready is combinational so a finished
// result can be drained and a new operand accepted on the same edge.
module mod_rem_serial
  import mod_rem_pkg::*;
#(
  parameter  int WIDTH   = 16,
  parameter  int MODULUS = 7,
  localparam int RW      = rem_width(MODULUS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RW-1:0]    out_rem,
`ifdef MODREM_QUOT_EN
  output logic [WIDTH-1:0] out_quot,
`endif
  output state_e           dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  if (!modulus_ok(MODULUS)) begin : g_bad_modulus
    $error("mod_rem_serial: MODULUS must be >= 2");
  end
  if (!width_ok(WIDTH, RW)) begin : g_bad_width
    $error("mod_rem_serial: WIDTH must be >= remainder width");
  end

  state_e           state_q;
  logic [WIDTH-1:0] sr_q;
  logic [RW-1:0]    acc_q;
  logic [CW-1:0]    cnt_q;
  logic             out_valid_q;
  logic [RW-1:0]    rem_q;
`ifdef MODREM_QUOT_EN
  logic [WIDTH-1:0] quot_q;
`endif

  logic [RW-1:0]    acc_next;
  logic             qbit;
  logic [WIDTH-1:0] sr_shift;

  mod_rem_step #(
    .MODULUS(MODULUS),
    .RW     (RW)
  ) u_step (
    .acc_i     (acc_q),
    .bit_i     (sr_q[WIDTH-1]),
    .acc_next_o(acc_next),
    .qbit_o    (qbit)
  );

  // The vacated LSB takes the quotient bit, so after WIDTH steps the shift
  // register holds the full quotient.
  if (WIDTH > 1) begin : g_shift_wide
    assign sr_shift = {sr_q[WIDTH-2:0], qbit};
  end else begin : g_shift_one
    assign sr_shift = qbit;
  end

  // Sequencer, datapath registers and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      rem_q       <= '0;
`ifdef MODREM_QUOT_EN
      quot_q      <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sr_q    <= in_data;
            acc_q   <= '0;
            cnt_q   <= CNT_LAST;
            state_q <= RUN;
          end
        end
        RUN: begin
          sr_q  <= sr_shift;
          acc_q <= acc_next;
          if (cnt_q == '0) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            rem_q       <= acc_next;
`ifdef MODREM_QUOT_EN
            quot_q      <= sr_shift;
`endif
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              sr_q    <= in_data;
              acc_q   <= '0;
              cnt_q   <= CNT_LAST;
              state_q <= RUN;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign out_valid = out_valid_q;
  assign out_rem   = rem_q;
`ifdef MODREM_QUOT_EN
  assign out_quot  = quot_q;
`endif
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mod_rem_serial.sv
// Bench for mod_rem_serial: unit 0 is WIDTH=16/MODULUS=7, unit 1 is
// WIDTH=16/MODULUS=8. Results are compared against plain a % M and a / M.
module tb_mod_rem_serial;
  import mod_rem_pkg::*;

  localparam int W  = 16;
  localparam int RW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid  [2];
  logic [W-1:0]  in_data   [2];
  logic          out_ready [2];
  logic          in_ready  [2];
  logic          out_valid [2];
  logic [RW-1:0] out_rem   [2];
`ifdef MODREM_QUOT_EN
  logic [W-1:0]  out_quot  [2];
`endif
  state_e        st        [2];

  mod_rem_serial #(.WIDTH(W), .MODULUS(7)) u_dut7 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid[0]),
    .in_ready (in_ready[0]),
    .in_data  (in_data[0]),
    .out_valid(out_valid[0]),
    .out_ready(out_ready[0]),
    .out_rem  (out_rem[0]),
`ifdef MODREM_QUOT_EN
    .out_quot (out_quot[0]),
`endif
    .dbg_state(st[0])
  );

  mod_rem_serial #(.WIDTH(W), .MODULUS(8)) u_dut8 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid[1]),
    .in_ready (in_ready[1]),
    .in_data  (in_data[1]),
    .out_valid(out_valid[1]),
    .out_ready(out_ready[1]),
    .out_rem  (out_rem[1]),
`ifdef MODREM_QUOT_EN
    .out_quot (out_quot[1]),
`endif
    .dbg_state(st[1])
  );

  // ---------------- scoreboard ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [W+RW-1:0] exp_q[$];  // {quotient, remainder}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Reference: integer division by the unit's modulus.
  function automatic logic [W+RW-1:0] ref_model(input int u, input logic [W-1:0] a);
    int m, av;
    m  = (u == 0) ? 7 : 8;
    av = int'(a);
    return {W'(av / m), RW'(av % m)};
  endfunction

  function automatic logic [31:0] cur_rem(input int u);
    return 32'(out_rem[u]);
  endfunction

`ifdef MODREM_QUOT_EN
  function automatic logic [31:0] cur_quot(input int u);
    return 32'(out_quot[u]);
  endfunction
`endif

  // ---------------- driver tasks ----------------
  // Presents one operand and returns just after the accepting edge.
  task automatic accept(input int u, input logic [W-1:0] a);
    int guard = 0;
    @(negedge clk);
    while (!in_ready[u] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_before_accept", 32'(in_ready[u]), 32'd1);
    in_valid[u] = 1'b1;
    in_data[u]  = a;
    @(posedge clk);
    exp_q.push_back(ref_model(u, a));
    #1 in_valid[u] = 1'b0;
  endtask

  // Counts edges from the accepting edge to out_valid and checks the result.
  task automatic wait_result(input int u);
    int lat = 0;
    logic [W+RW-1:0] e;
    while (!out_valid[u] && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(W));
    if (exp_q.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("rem", cur_rem(u), 32'(e[RW-1:0]));
`ifdef MODREM_QUOT_EN
      check("quot", cur_quot(u), 32'(e[W+RW-1:RW]));
`endif
    end
  endtask

  // Holds back-pressure for 'hold' cycles, then completes one handshake.
  task automatic drain(input int u, input int hold);
    logic [31:0] r0;
    r0 = cur_rem(u);
`ifdef MODREM_QUOT_EN
    begin
      logic [31:0] q0;
      q0 = cur_quot(u);
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid[u] = 1'b1;
      in_data[u]  = W'($urandom);
      check("bp_in_ready", 32'(in_ready[u]), 32'd0);
      @(posedge clk);
      #1;
      check("bp_out_valid", 32'(out_valid[u]), 32'd1);
      check("bp_rem_stable", cur_rem(u), r0);
`ifdef MODREM_QUOT_EN
      check("bp_quot_stable", cur_quot(u), q0);
`endif
    end
`ifdef MODREM_QUOT_EN
    end
`endif
    @(negedge clk);
    in_valid[u]  = 1'b0;
    out_ready[u] = 1'b1;
    @(posedge clk);
    #1 out_ready[u] = 1'b0;
    check("drain_out_valid", 32'(out_valid[u]), 32'd0);
    check("drain_in_ready", 32'(in_ready[u]), 32'd1);
  endtask

  task automatic op(input int u, input logic [W-1:0] a, input int hold);
    accept(u, a);
    wait_result(u);
    drain(u, hold);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      in_valid[u]  = 1'b0;
      in_data[u]   = '0;
      out_ready[u] = 1'b0;
    end
    #22;
    for (int u = 0; u < 2; u++) begin
      check("reset_out_valid", 32'(out_valid[u]), 32'd0);
      check("reset_in_ready", 32'(in_ready[u]), 32'd1);
      check("reset_rem", cur_rem(u), 32'd0);
`ifdef MODREM_QUOT_EN
      check("reset_quot", cur_quot(u), 32'd0);
`endif
      check("reset_state", 32'(st[u]), 32'(IDLE));
    end
    @(negedge clk);
    rst = 1'b0;

    // Directed operands, modulus 7.
    op(0, 16'd13, 0);
    op(0, 16'd65535, 0);
    op(0, 16'd1000, 0);
    op(0, 16'd0, 0);
    // Back-pressure: five stalled cycles with competing in_valid.
    op(0, 16'd13, 5);

    // Back-to-back with in_valid and out_ready held high.
    @(negedge clk);
    in_valid[0]  = 1'b1;
    in_data[0]   = 16'd13;
    out_ready[0] = 1'b1;
    @(posedge clk);
    exp_q.push_back(ref_model(0, 16'd13));
    #1 in_data[0] = 16'd20;
    wait_result(0);
    check("b2b_in_ready_in_done", 32'(in_ready[0]), 32'd1);
    @(posedge clk);
    exp_q.push_back(ref_model(0, 16'd20));
    #1 in_valid[0] = 1'b0;
    check("b2b_no_bubble_state", 32'(st[0]), 32'(RUN));
    check("b2b_out_valid_dropped", 32'(out_valid[0]), 32'd0);
    wait_result(0);
    @(posedge clk);
    #1 out_ready[0] = 1'b0;
    check("b2b_final_drain", 32'(out_valid[0]), 32'd0);

    // Reset mid-RUN aborts the operation.
    accept(0, 16'd1234);
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrun_rst_out_valid", 32'(out_valid[0]), 32'd0);
    check("midrun_rst_in_ready", 32'(in_ready[0]), 32'd1);
    check("midrun_rst_state", 32'(st[0]), 32'(IDLE));
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    op(0, 16'd49, 0);

    // Reset while a result is waiting drops out_valid without a clock edge.
    accept(0, 16'd777);
    wait_result(0);
    #2 rst = 1'b1;
    #1 check("done_rst_out_valid", 32'(out_valid[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Power-of-two modulus.
    op(1, 16'hABCD, 0);
    op(1, 16'hFFFF, 1);
    op(1, 16'd8, 0);
    op(1, 16'd0, 0);

    // Random sweep over both units.
    for (int i = 0; i < 40; i++) begin
      op($urandom_range(0, 1), W'($urandom), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
